// File: rtl/stencil_src_pkg.sv
// Shared types and constants for the stencil stream source.
package stencil_src_pkg;

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PAT_LFSR = 1'b0,
    PAT_RAMP = 1'b1
  } pattern_e;

  localparam int          PIX_W         = 16;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

endpackage

// File: rtl/stencil_lfsr16.sv
// One combinational step of the 16-bit Fibonacci LFSR.
module stencil_lfsr16
  import stencil_src_pkg::*;
(
  input  logic [15:0] cur_i,
  output logic [15:0] next_o
);

  // Shift left and feed the XOR of the tapped bits back into bit 0.
  assign next_o = {cur_i[14:0], ^(cur_i & LFSR_TAP_MASK)};

endmodule

// File: rtl/stencil_stream_source.sv
// Zero-latency pixel stream source: config hold-off, then one frame of
// LFSR or ramp pixels popped by the consumer, then idle until flush/reset.
module stencil_stream_source
  import stencil_src_pkg::*;
#(
  parameter int          IMG_W         = 64,
  parameter int          IMG_H         = 64,
  parameter int          CONFIG_CYCLES = 409,
  parameter int          PATTERN       = 0,
  parameter logic [15:0] SEED          = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  output logic [15:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read,
  output logic        ready,
  output logic        frame_done,
  output logic        protocol_err,
  output logic [31:0] pixel_count
);

  localparam int          COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [31:0] CFG_LAST = (CONFIG_CYCLES == 0) ? 32'd0 : 32'(CONFIG_CYCLES - 1);
  localparam logic [15:0] PIX_INIT = (PATTERN == int'(PAT_RAMP)) ? 16'h0000 : SEED;

  state_e           state_q, state_d;
  logic [31:0]      cfg_cnt_q, cfg_cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]      pix_q, pix_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;
  logic [15:0]      lfsr_next;
  logic             rd_en;

  assign rd_en = hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en;

  stencil_lfsr16 u_lfsr (
    .cur_i  (pix_q),
    .next_o (lfsr_next)
  );

  // Next-state logic: flush overrides everything, pops only count in STREAM.
  always_comb begin
    state_d   = state_q;
    cfg_cnt_d = cfg_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = pix_q;
    cnt_d     = cnt_q;
    perr_d    = perr_q;
    if (flush) begin
      state_d = ST_STREAM;
      col_d   = '0;
      row_d   = '0;
      cnt_d   = '0;
      pix_d   = PIX_INIT;
      perr_d  = 1'b0;
    end else begin
      case (state_q)
        ST_CONFIG: begin
          if (rd_en) perr_d = 1'b1;
          if (CONFIG_CYCLES == 0 || cfg_cnt_q == CFG_LAST) state_d = ST_STREAM;
          else                                             cfg_cnt_d = cfg_cnt_q + 32'd1;
        end
        ST_STREAM: begin
          if (rd_en) begin
            cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            pix_d = (PATTERN == int'(PAT_RAMP)) ? cnt_d[15:0] : lfsr_next;
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                row_d   = '0;
                state_d = ST_DONE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (rd_en) perr_d = 1'b1;
        end
        default: state_d = ST_CONFIG;
      endcase
    end
  end

  assign ready_d = (state_d == ST_STREAM);
  assign done_d  = (state_d == ST_DONE);

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CONFIG;
      cfg_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pix_q     <= PIX_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_cnt_q <= cfg_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pix_q     <= pix_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
    end
  end

  // Pixel register is exposed directly so data is valid in the pop cycle.
  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read =
    (state_q == ST_STREAM) ? pix_q : 16'h0000;

  assign ready        = ready_q;
  assign frame_done   = done_q;
  assign protocol_err = perr_q;
  assign pixel_count  = cnt_q;

endmodule

// File: tb/tb_stencil_stream_source.sv
// Bench for stencil_stream_source: LFSR instance plus a ramp instance.
module tb_stencil_stream_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, ren = 1'b0;
  logic        flush_r = 1'b0, ren_r = 1'b0;
  logic [15:0] data, data_r;
  logic        ready, done, perr;
  logic        ready_r, done_r, perr_r;
  logic [31:0] cnt, cnt_r;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pix, want;

  always #5 clk = ~clk;

  stencil_stream_source #(.IMG_W(4), .IMG_H(2), .CONFIG_CYCLES(3), .PATTERN(0), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en(ren),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read(data),
    .ready(ready), .frame_done(done), .protocol_err(perr), .pixel_count(cnt));

  stencil_stream_source #(.IMG_W(4), .IMG_H(2), .CONFIG_CYCLES(3), .PATTERN(1), .SEED(16'hACE1)) dut_r (
    .clk(clk), .rst_n(rst_n), .flush(flush_r),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en(ren_r),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read(data_r),
    .ready(ready_r), .frame_done(done_r), .protocol_err(perr_r), .pixel_count(cnt_r));

  function automatic logic [15:0] model_lfsr(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; ren = 1'b0; flush = 1'b0;
    #1;
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_chk++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data); end
    n_chk++; if ({done, perr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {done, perr}); end
    n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt); end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_chk++; if (ready !== (e == 3)) begin n_fail++; $display("FAIL config_ready_edge%0d: got %b want %b", e, ready, (e == 3)); end
    end
  endtask

  task automatic test_stream();
    exp_pix = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL stream_done_early%0d: got %b want 0", i, done); end
      exp_q.push_back(exp_pix);
      ren = 1'b1;
      want = exp_q.pop_front();
      n_chk++; if (data !== want) begin n_fail++; $display("FAIL stream_pix%0d: got %h want %h", i, data, want); end
      if (i == 1) begin
        n_chk++; if (data !== 16'h59C3) begin n_fail++; $display("FAIL stream_second: got %h want 59c3", data); end
      end
      exp_pix = model_lfsr(exp_pix);
      @(negedge clk);
    end
    ren = 1'b0;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL stream_done: got %b want 1", done); end
    n_chk++; if (cnt !== 32'd8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", cnt); end
    n_chk++; if (ready !== 1'b0 || data !== 16'h0000) begin n_fail++; $display("FAIL stream_done_out: got rdy=%b data=%h want 0/0000", ready, data); end
  endtask

  task automatic test_done_pop();
    ren = 1'b1;
    @(negedge clk); ren = 1'b0;
    n_chk++; if (perr !== 1'b1) begin n_fail++; $display("FAIL done_pop_perr: got %b want 1", perr); end
    n_chk++; if (data !== 16'h0000) begin n_fail++; $display("FAIL done_pop_data: got %h want 0000", data); end
    n_chk++; if (cnt !== 32'd8 || done !== 1'b1) begin n_fail++; $display("FAIL done_pop_hold: got cnt=%0d done=%b want 8/1", cnt, done); end
  endtask

  task automatic test_config_pop();
    @(negedge clk); rst_n = 1'b0;
    #1;
    @(negedge clk); rst_n = 1'b1; ren = 1'b1;
    @(negedge clk); ren = 1'b0;
    n_chk++; if (perr !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL config_pop: got perr=%b rdy=%b want 1/0", perr, ready); end
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL config_pop_ready: got %b want 1", ready); end
    n_chk++; if (data !== 16'hACE1) begin n_fail++; $display("FAIL config_pop_first: got %h want ace1", data); end
    n_chk++; if (perr !== 1'b1 || cnt !== 32'd0) begin n_fail++; $display("FAIL config_pop_sticky: got perr=%b cnt=%0d want 1/0", perr, cnt); end
  endtask

  task automatic test_ramp();
    int seq[4] = '{1, 0, 1, 1};
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 4; i++) begin
      ren_r = seq[i][0];
      exp_q.push_back(r);
      want = exp_q.pop_front();
      n_chk++; if (data_r !== want) begin n_fail++; $display("FAIL ramp_pix%0d: got %h want %h", i, data_r, want); end
      if (seq[i] == 1) r = r + 16'd1;
      @(negedge clk);
    end
    ren_r = 1'b0;
    n_chk++; if (cnt_r !== 32'd3) begin n_fail++; $display("FAIL ramp_count: got %0d want 3", cnt_r); end
    n_chk++; if (data_r !== 16'd3) begin n_fail++; $display("FAIL ramp_last: got %h want 0003", data_r); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_chk++; if (perr !== 1'b0 || cnt !== 32'd0 || data !== 16'hACE1) begin n_fail++; $display("FAIL flush_clear: got perr=%b cnt=%0d data=%h want 0/0/ace1", perr, cnt, data); end
    exp_pix = 16'hACE1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_pix);
      ren = 1'b1;
      want = exp_q.pop_front();
      n_chk++; if (data !== want) begin n_fail++; $display("FAIL flush_pix%0d: got %h want %h", i, data, want); end
      exp_pix = model_lfsr(exp_pix);
      @(negedge clk);
    end
    n_chk++; if (cnt !== 32'd5 || data !== exp_pix) begin n_fail++; $display("FAIL flush_at5: got cnt=%0d data=%h want 5/%h", cnt, data, exp_pix); end
    flush = 1'b1; ren = 1'b1;
    @(negedge clk); flush = 1'b0; ren = 1'b0;
    n_chk++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL flush_pop_count: got %0d want 0", cnt); end
    n_chk++; if (data !== 16'hACE1) begin n_fail++; $display("FAIL flush_pop_data: got %h want ace1", data); end
    n_chk++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL flush_pop_state: got rdy=%b done=%b want 1/0", ready, done); end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 3; i++) begin
      ren = 1'b1;
      @(negedge clk);
    end
    ren = 1'b0;
    n_chk++; if (cnt !== 32'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 3", cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (ready !== 1'b0 || data !== 16'h0000 || cnt !== 32'd0) begin n_fail++; $display("FAIL mid_async_clear: got rdy=%b data=%h cnt=%0d want 0/0000/0", ready, data, cnt); end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_chk++; if (ready !== (e == 3)) begin n_fail++; $display("FAIL mid_config_edge%0d: got %b want %b", e, ready, (e == 3)); end
    end
    n_chk++; if (data !== 16'hACE1) begin n_fail++; $display("FAIL mid_restart_seed: got %h want ace1", data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_done_pop();
    test_config_pop();
    test_ramp();
    test_flush();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
